// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter with a registered register-file write port and a
// 32-entry pending-write scoreboard for source-operand hazard checks.
module wb_arbiter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            r0_valid,
    input  logic [4:0]      r0_addr,
    input  logic [XLEN-1:0] r0_data,
    output logic            r0_ready,

    input  logic            r1_valid,
    input  logic [4:0]      r1_addr,
    input  logic [XLEN-1:0] r1_data,
    output logic            r1_ready,

    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,

    input  logic            iss_valid,
    input  logic [4:0]      iss_addr,

    input  logic [4:0]      chk_addr1,
    input  logic [4:0]      chk_addr2,
    output logic            busy1,
    output logic            busy2
);

    // 1 means requester 1 was granted most recently, so requester 0 wins the next tie.
    logic            last_grant_q;

    logic            wb_en_q;
    logic [4:0]      wb_addr_q;
    logic [XLEN-1:0] wb_data_q;

    logic [31:0]     busy_q;
    logic [31:0]     busy_d;

    logic            xfer;
    logic [4:0]      win_addr;
    logic [XLEN-1:0] win_data;

    always_comb begin
        r0_ready = reset & r0_valid & (~r1_valid | last_grant_q);
        r1_ready = reset & r1_valid & (~r0_valid | ~last_grant_q);
    end

    always_comb begin
        xfer     = r0_ready | r1_ready;
        win_addr = r1_ready ? r1_addr : r0_addr;
        win_data = r1_ready ? r1_data : r0_data;
    end

    // Issue is applied after the clear so a same-edge set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[win_addr] = 1'b0;
        end
        if (iss_valid) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // A register stays busy through the wb stage until its value is in the register file.
    always_comb begin
        busy1 = (chk_addr1 != 5'd0) &&
                (busy_q[chk_addr1] || (wb_en_q && (wb_addr_q == chk_addr1)));
        busy2 = (chk_addr2 != 5'd0) &&
                (busy_q[chk_addr2] || (wb_en_q && (wb_addr_q == chk_addr2)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            wb_en_q      <= 1'b0;
            wb_addr_q    <= 5'd0;
            wb_data_q    <= '0;
            busy_q       <= '0;
        end else begin
            if (xfer) begin
                last_grant_q <= r1_ready;
                wb_addr_q    <= win_addr;
                wb_data_q    <= win_data;
            end
            wb_en_q <= xfer && (win_addr != 5'd0);
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        wb_en   = wb_en_q;
        wb_addr = wb_addr_q;
        wb_data = wb_data_q;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: XLEN, 64, writeback data width.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; while low all state is cleared immediately.
REQ-004 Port: r0_valid / r0_addr / r0_data  input  1 / 5 / XLEN  requester 0 (ALU) writeback request.
REQ-005 Port: r0_ready  output  1  requester 0 is granted this cycle.
REQ-006 Port: r1_valid / r1_addr / r1_data  input  1 / 5 / XLEN  requester 1 (MEM) writeback request.
REQ-007 Port: r1_ready  output  1  requester 1 is granted this cycle.
REQ-008 Port: wb_en / wb_addr / wb_data  output  1 / 5 / XLEN  registered register-file write port.
REQ-009 Port: iss_valid / iss_addr  input  1 / 5  an instruction issues and claims destination iss_addr.
REQ-010 Port: chk_addr1 / chk_addr2  input  5 / 5  source registers to test.
REQ-011 Port: busy1 / busy2  output  1 / 1  combinational: the source register has a pending writeback.

Function
REQ-012 Handshake: a transfer occurs when rN_valid and rN_ready are both high in the same cycle; rN_ready is combinational from the valids and the arbitration pointer.
REQ-013 Requesters hold valid, addr and data stable until the transfer occurs; the arbiter does not buffer ungranted requests.
REQ-014 At most one rN_ready is high per cycle.
REQ-015 Only one valid: that requester is granted.
REQ-016 Both valid: round-robin arbitration. The requester not granted most recently wins. The last_grant flop updates only on a transfer.
REQ-017 Latency is 1 cycle. A transfer at edge T drives wb_en=1 with the winner's addr/data during cycle T+1.
REQ-018 wb_en is low in every cycle that follows a cycle with no transfer.
REQ-019 Writes to x0: the transfer completes (ready high) but wb_en stays 0 in the following cycle.
REQ-020 Scoreboard: 32 busy bits; bit 0 is hardwired to 0.
REQ-021 iss_valid with iss_addr != 0 sets busy[iss_addr] at the edge.
REQ-022 A transfer clears busy[addr] at the same edge it is accepted, not at the later wb_en cycle.
REQ-023 Simultaneous set and clear of the same register at one edge: set wins, so the newer producer stays pending.
REQ-024 busyN = busy[chk_addrN] OR (a transfer is in flight in the wb stage, wb_en=1 and wb_addr==chk_addrN). A register is therefore reported busy until its value is visible in the register file.
REQ-025 chk_addrN == 0 always gives busyN = 0.
REQ-026 A transfer for a register whose busy bit is already 0 is legal. The write proceeds and the bit stays 0.
REQ-027 Two consecutive transfers to the same address produce two wb_en cycles in order; the second write overwrites the first.

Reset
REQ-028 While reset is low: wb_en=0, wb_addr=0, wb_data=0, all busy bits 0, last_grant=1 (requester 0 wins the first tie).
REQ-029 r0_ready and r1_ready are 0 while reset is low, regardless of the valids.
REQ-030 Reset asserted mid-operation discards any in-flight wb-stage write (wb_en drops immediately) and all pending busy bits.
REQ-031 The first edge after reset deasserts behaves as a normal cycle.

Verification
REQ-032 Tie rotation: r0 and r1 both valid for 4 cycles, r0_addr=5, r1_addr=6 -> grants in the order r0,r1,r0,r1; wb_en=1 on cycles 2-5 with wb_addr 5,6,5,6.
REQ-033 x0 suppression: r1_valid, r1_addr=0, r1_data=0xDEAD -> r1_ready=1, next cycle wb_en=0, busy bits unchanged.
REQ-034 Scoreboard lifecycle: issue x7, then chk_addr1=7 -> busy1=1. r0 transfer to x7 at edge T -> busy1 stays 1 during T+1 (wb stage), then 0 at T+2.
REQ-035 Set/clear race: iss_addr=9 and an r0 transfer to x9 at the same edge -> busy[9]=1 afterward; wb_en=1 with wb_addr=9 next cycle.
REQ-036 Async reset mid-write: reset driven low between edges while wb_en=1 -> wb_en=0 and busy1=busy2=0 without waiting for a clock edge. After release, a tie grants r0 first.
REQ-037 Single requester streaming: r1_valid held for 3 cycles, r0 idle -> r1_ready=1 on each cycle; no bubbles on wb_en.
